// File: rtl/proc_stim_engine.sv
// rtl/proc_stim_engine.sv - program ROM, scratch RAM and write checker that drives the single-cycle processor; PROC_STIM_TRACE_EN adds a write trace FIFO
module proc_stim_engine #(
    parameter int DATA_WIDTH      = 32,
    parameter int PROG_DEPTH      = 16,
    parameter int NUM_CHECKS      = 4,
    parameter int NUM_RAM_ADDRESS = 256,
    parameter int MAX_CYCLES      = 64,
`ifdef PROC_STIM_TRACE_EN
    parameter int TRACE_DEPTH     = 8,
`endif
    localparam int PA = $clog2(PROG_DEPTH),
    localparam int CA = $clog2(NUM_CHECKS),
    localparam int RA = $clog2(NUM_RAM_ADDRESS),
    localparam int IW = (PA > CA) ? PA : CA,
    localparam int CW = $clog2(MAX_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  load_sel,
    input  logic [IW-1:0]         load_index,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [RA-1:0]         load_exp_addr,
    input  logic                  start,
    output logic                  proc_reset,
    output logic                  enable,
    input  logic [RA-1:0]         rom_address,
    output logic [DATA_WIDTH-1:0] instruction,
    input  logic [RA-1:0]         ram_address,
    input  logic [DATA_WIDTH-1:0] ram_data_write_out,
    input  logic                  ram_enable,
    input  logic                  ram_read_write,
    output logic [DATA_WIDTH-1:0] ram_data_read_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CA:0]           fail_index,
`ifdef PROC_STIM_TRACE_EN
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [RA-1:0]         trace_addr,
    output logic [DATA_WIDTH-1:0] trace_data,
    output logic                  trace_overflow,
`endif
    output logic [CW-1:0]         cycle_count
);

    localparam int CCW = CA + 1;

    typedef enum logic [1:0] {IDLE, PRST, RUN, DONE} state_t;

    state_t                state, state_next;
    logic                  prst_cnt;
    logic [DATA_WIDTH-1:0] prog_mem [PROG_DEPTH];
    logic [RA-1:0]         chk_addr [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] chk_data [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] scratch  [NUM_RAM_ADDRESS];
    logic [CA:0]           check_count;
    logic [CA:0]           match_cnt;
    logic                  load_fire, start_ok, write_ev;
    logic                  chk_active, chk_hit, chk_last, check_stop, run_timeout;

    assign load_fire  = load_valid && load_ready;
    assign start_ok   = start && (state == IDLE || state == DONE);
    assign write_ev   = (state == RUN) && ram_enable && ram_read_write;
    // Only writes up to check_count are compared; later ones just land in scratch RAM.
    assign chk_active = match_cnt < check_count;
    assign chk_hit    = (ram_address == chk_addr[match_cnt[CA-1:0]])
                     && (ram_data_write_out == chk_data[match_cnt[CA-1:0]]);
    assign chk_last   = (match_cnt + 1'b1) == check_count;
    assign check_stop = write_ev && chk_active && (!chk_hit || chk_last);
    // The edge that takes cycle_count to MAX_CYCLES is the last RUN edge.
    assign run_timeout = (state == RUN) && (cycle_count == CW'(MAX_CYCLES - 1));

    assign instruction = (state == RUN && int'(rom_address) < PROG_DEPTH)
                       ? prog_mem[rom_address[PA-1:0]] : '0;
    assign ram_data_read_in = scratch[ram_address];

    // State register; the PRST phase counter runs only while in PRST.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            prst_cnt <= 1'b0;
        end else begin
            state    <= state_next;
            prst_cnt <= (state == PRST) ? ~prst_cnt : 1'b0;
        end
    end

    // Next state and processor control outputs.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        enable     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        proc_reset = !reset;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                proc_reset = 1'b1;
                if (start) state_next = PRST;
            end
            PRST: begin
                busy       = 1'b1;
                proc_reset = 1'b1;
                if (prst_cnt) state_next = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                enable = 1'b1;
                if (check_stop || run_timeout) state_next = DONE;
            end
            DONE: begin
                load_ready = 1'b1;
                done       = 1'b1;
                if (start) state_next = PRST;
            end
            default: state_next = IDLE;
        endcase
    end

    // Program and expected-write tables survive reset so a harness can be reloaded selectively.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            if (!load_sel && int'(load_index) < PROG_DEPTH)
                prog_mem[load_index[PA-1:0]] <= load_data;
            if (load_sel && int'(load_index) < NUM_CHECKS) begin
                chk_addr[load_index[CA-1:0]] <= load_exp_addr;
                chk_data[load_index[CA-1:0]] <= load_data;
            end
        end
    end

    // Check count, match progress, run result and cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            check_count <= '0;
            match_cnt   <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_index  <= '0;
            cycle_count <= '0;
        end else begin
            if (load_fire && load_sel && int'(load_index) < NUM_CHECKS
                && int'(load_index) >= int'(check_count))
                check_count <= CCW'(load_index) + 1'b1;
            if (start_ok) begin
                match_cnt   <= '0;
                pass        <= 1'b0;
                timeout     <= 1'b0;
                fail_index  <= '0;
                cycle_count <= '0;
            end else if (state == RUN) begin
                if (cycle_count != CW'(MAX_CYCLES))
                    cycle_count <= cycle_count + 1'b1;
                // A check decision at the timeout edge takes precedence over the timeout.
                if (write_ev && chk_active) begin
                    if (chk_hit) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (chk_last) begin
                            pass       <= 1'b1;
                            fail_index <= match_cnt + 1'b1;
                        end
                    end else begin
                        pass       <= 1'b0;
                        fail_index <= match_cnt;
                    end
                end else if (run_timeout) begin
                    timeout    <= 1'b1;
                    pass       <= (check_count == '0);
                    fail_index <= match_cnt;
                end
            end
        end
    end

    // Scratch RAM: cleared on reset and at every launch, written by RUN write events.
    always_ff @(posedge clk) begin
        if (!reset || start_ok) begin
            for (int i = 0; i < NUM_RAM_ADDRESS; i++) scratch[i] <= '0;
        end else if (write_ev) begin
            scratch[ram_address] <= ram_data_write_out;
        end
    end

`ifdef PROC_STIM_TRACE_EN
    localparam int TA  = $clog2(TRACE_DEPTH);
    localparam int TCW = TA + 1;

    logic [RA+DATA_WIDTH-1:0] trace_mem [TRACE_DEPTH];
    logic [TA-1:0]            trace_wp, trace_rp;
    logic [TA:0]              trace_cnt;
    logic                     trace_push, trace_pop;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign trace_pop   = trace_valid && trace_ready;
    assign trace_push  = write_ev && (trace_cnt != TCW'(TRACE_DEPTH) || trace_pop);
    assign trace_valid = trace_cnt != '0;
    assign {trace_addr, trace_data} = trace_mem[trace_rp];

    // Trace storage; pointers wrap naturally for a power-of-two depth.
    always_ff @(posedge clk) begin
        if (trace_push) trace_mem[trace_wp] <= {ram_address, ram_data_write_out};
    end

    // Trace pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset || start_ok) begin
            trace_wp       <= '0;
            trace_rp       <= '0;
            trace_cnt      <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (trace_push) trace_wp <= trace_wp + 1'b1;
            if (trace_pop)  trace_rp <= trace_rp + 1'b1;
            if (write_ev && !trace_push) trace_overflow <= 1'b1;
            if (trace_push && !trace_pop)      trace_cnt <= trace_cnt + 1'b1;
            else if (!trace_push && trace_pop) trace_cnt <= trace_cnt - 1'b1;
        end
    end
`endif

endmodule
